rf_port_arbiter: RTL and testbench

- Shares the 32x64 two-read/one-write `register_file` between NUM_RD_REQ operand-fetch requesters and two writeback sources (ALU, memory).
- Read side: round-robin, one requester granted per cycle; the grant uses both RF read ports.
- Write side: writebacks go into a small 2-in/1-out write FIFO, which drains one entry per cycle into the RF write port.
- RAW hazard check: a read touching any pending write address is stalled until that write has reached the RF.

---
 rtl/rf_arb_pkg.sv | 13 +
 rtl/rf_wb_fifo.sv | 77 +++++++
 rtl/rf_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rf_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file port arbiter: default widths and the
// write-FIFO entry layout.
package rf_arb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 64;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback FIFO with two enqueue ports (port 0 is enqueued first) and one
// dequeue per cycle. It pops whenever it is non-empty and reports address hits against live entries.
module rf_wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int NUM_Q    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enq0_valid,
    input  wb_entry_t                            enq0_entry,
    input  logic                                 enq1_valid,
    input  wb_entry_t                            enq1_entry,
    input  logic [NUM_Q-1:0][1:0][RF_ADDR_W-1:0] q_addr,
    output logic [NUM_Q-1:0][1:0]                pending_hit,
    output logic [$clog2(WB_DEPTH+1)-1:0]        count,
    output logic                                 empty,
    output wb_entry_t                            head
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    wb_entry_t           mem_q [WB_DEPTH];
    wb_entry_t           mem_d [WB_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, tail1;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                deq;
    logic [PTR_W-1:0]    off;
    logic [WB_DEPTH-1:0] live;

    always_comb begin
        mem_d   = mem_q;
        deq     = (count_q != '0);
        tail1   = enq0_valid ? tail_q + PTR_W'(1) : tail_q;
        if (enq0_valid) mem_d[tail_q] = enq0_entry;
        if (enq1_valid) mem_d[tail1]  = enq1_entry;
        head_d  = head_q + PTR_W'(deq);
        tail_d  = tail_q + PTR_W'(enq0_valid) + PTR_W'(enq1_valid);
        count_d = count_q + CNT_W'(enq0_valid) + CNT_W'(enq1_valid) - CNT_W'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // The head stays live during its drain cycle, so it still blocks matching reads.
    always_comb begin
        live        = '0;
        off         = '0;
        pending_hit = '0;
        for (int e = 0; e < WB_DEPTH; e++) begin
            off     = PTR_W'(e) - head_q;
            live[e] = CNT_W'(off) < count_q;
        end
        for (int q = 0; q < NUM_Q; q++)
            for (int op = 0; op < 2; op++)
                for (int e = 0; e < WB_DEPTH; e++)
                    if (live[e] && mem_q[e].addr == q_addr[q][op]) pending_hit[q][op] = 1'b1;
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign head  = mem_q[head_q];

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares a 2R/1W register file between round-robin operand-fetch requesters
// and the ALU/memory writeback paths, stalling reads that hit pending writes.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_RD_REQ = 2,
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int WB_DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_RD_REQ-1:0]                 rd_req_valid,
    input  logic [NUM_RD_REQ-1:0][ADDR_W-1:0]     rd_req_addr0,
    input  logic [NUM_RD_REQ-1:0][ADDR_W-1:0]     rd_req_addr1,
    input  logic [NUM_RD_REQ-1:0][1:0]            rd_req_use,
    output logic [NUM_RD_REQ-1:0]                 rd_req_ready,
    output logic                                  rd_rsp_valid,
    output logic [$clog2(NUM_RD_REQ)-1:0]         rd_rsp_id,
    output logic [DATA_W-1:0]                     rd_rsp_data0,
    output logic [DATA_W-1:0]                     rd_rsp_data1,
    input  logic                                  wb_mem_valid,
    output logic                                  wb_mem_ready,
    input  logic [ADDR_W-1:0]                     wb_mem_addr,
    input  logic [DATA_W-1:0]                     wb_mem_data,
    input  logic                                  wb_alu_valid,
    output logic                                  wb_alu_ready,
    input  logic [ADDR_W-1:0]                     wb_alu_addr,
    input  logic [DATA_W-1:0]                     wb_alu_data,
    output logic [1:0]                            rf_read_en,
    output logic [ADDR_W-1:0]                     rf_raddr_0,
    output logic [ADDR_W-1:0]                     rf_raddr_1,
    input  logic [DATA_W-1:0]                     rf_rdata_0,
    input  logic [DATA_W-1:0]                     rf_rdata_1,
    output logic                                  rf_write_en,
    output logic [ADDR_W-1:0]                     rf_waddr,
    output logic [DATA_W-1:0]                     rf_wdata
);

    localparam int ID_W  = $clog2(NUM_RD_REQ);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic [ID_W-1:0]   rr_q, rr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;

    logic [CNT_W-1:0]  wb_count, free;
    logic              wb_empty, mem_acc, alu_acc;
    wb_entry_t         wb_head, mem_ent, alu_ent;

    logic [NUM_RD_REQ-1:0][1:0][ADDR_W-1:0] q_addr;
    logic [NUM_RD_REQ-1:0][1:0]             pending_hit;
    logic [NUM_RD_REQ-1:0]                  blocked, eligible;
    logic [ADDR_W-1:0]                      op_addr;
    logic                                   hit, gnt_any;
    logic [ID_W-1:0]                        gnt_id;
    int                                     idx;

    always_comb begin
        for (int i = 0; i < NUM_RD_REQ; i++) begin
            q_addr[i][0] = rd_req_addr0[i];
            q_addr[i][1] = rd_req_addr1[i];
        end
    end

    assign mem_ent = '{addr: wb_mem_addr, data: wb_mem_data};
    assign alu_ent = '{addr: wb_alu_addr, data: wb_alu_data};

    rf_wb_fifo #(
        .WB_DEPTH (WB_DEPTH),
        .NUM_Q    (NUM_RD_REQ)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (reset),
        .enq0_valid  (mem_acc),
        .enq0_entry  (mem_ent),
        .enq1_valid  (alu_acc),
        .enq1_entry  (alu_ent),
        .q_addr      (q_addr),
        .pending_hit (pending_hit),
        .count       (wb_count),
        .empty       (wb_empty),
        .head        (wb_head)
    );

    // Space is judged on the start-of-cycle count; this cycle's pop frees nothing yet.
    always_comb begin
        free         = CNT_W'(WB_DEPTH) - wb_count;
        wb_mem_ready = !reset && (free != '0);
        wb_alu_ready = !reset && ((free >= CNT_W'(2)) || ((free != '0) && !wb_mem_valid));
        mem_acc      = wb_mem_valid && wb_mem_ready;
        alu_acc      = wb_alu_valid && wb_alu_ready;
    end

    always_comb begin
        blocked = '0;
        op_addr = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_RD_REQ; i++) begin
            for (int op = 0; op < 2; op++) begin
                op_addr = q_addr[i][op];
                hit     = pending_hit[i][op]
                       || (mem_acc && wb_mem_addr == op_addr)
                       || (alu_acc && wb_alu_addr == op_addr);
                if (rd_req_use[i][op] && hit) blocked[i] = 1'b1;
            end
        end
        eligible = rd_req_valid & ~blocked & {NUM_RD_REQ{!reset}};

        // Walk backwards so the requester closest to the pointer wins last.
        gnt_any = 1'b0;
        gnt_id  = rr_q;
        idx     = 0;
        for (int k = NUM_RD_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_RD_REQ;
            if (eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        rd_req_ready = '0;
        rf_read_en   = '0;
        rf_raddr_0   = '0;
        rf_raddr_1   = '0;
        rr_d         = rr_q;
        rsp_valid_d  = gnt_any;
        rsp_id_d     = '0;
        rsp_data0_d  = '0;
        rsp_data1_d  = '0;
        if (gnt_any) begin
            rd_req_ready[gnt_id] = 1'b1;
            rf_read_en           = rd_req_use[gnt_id];
            if (rd_req_use[gnt_id][0]) begin
                rf_raddr_0  = rd_req_addr0[gnt_id];
                rsp_data0_d = rf_rdata_0;
            end
            if (rd_req_use[gnt_id][1]) begin
                rf_raddr_1  = rd_req_addr1[gnt_id];
                rsp_data1_d = rf_rdata_1;
            end
            rsp_id_d = gnt_id;
            rr_d     = ID_W'((int'(gnt_id) + 1) % NUM_RD_REQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_id    = rsp_id_q;
    assign rd_rsp_data0 = rsp_data0_q;
    assign rd_rsp_data1 = rsp_data1_q;

    assign rf_write_en  = !wb_empty;
    assign rf_waddr     = wb_empty ? '0 : wb_head.addr;
    assign rf_wdata     = wb_empty ? '0 : wb_head.data;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomised and directed bench for rf_port_arbiter: a queue/array reference
// model predicts every cycle, and a scoreboard checks read responses.
module tb_rf_port_arbiter;

    localparam int N = 2, DW = 64, AW = 5, DEPTH = 4;

    logic clk = 1'b0;
    logic reset, preload;
    logic [N-1:0]         rd_req_valid, rd_req_ready;
    logic [N-1:0][AW-1:0] rd_req_addr0, rd_req_addr1;
    logic [N-1:0][1:0]    rd_req_use;
    logic                 rd_rsp_valid;
    logic [0:0]           rd_rsp_id;
    logic [DW-1:0]        rd_rsp_data0, rd_rsp_data1;
    logic                 wb_mem_valid, wb_mem_ready, wb_alu_valid, wb_alu_ready;
    logic [AW-1:0]        wb_mem_addr, wb_alu_addr;
    logic [DW-1:0]        wb_mem_data, wb_alu_data;
    logic [1:0]           rf_read_en;
    logic [AW-1:0]        rf_raddr_0, rf_raddr_1, rf_waddr;
    logic [DW-1:0]        rf_rdata_0, rf_rdata_1, rf_wdata;
    logic                 rf_write_en;

    rf_port_arbiter dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_addr0(rd_req_addr0), .rd_req_addr1(rd_req_addr1),
        .rd_req_use(rd_req_use), .rd_req_ready(rd_req_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_id(rd_rsp_id),
        .rd_rsp_data0(rd_rsp_data0), .rd_rsp_data1(rd_rsp_data1),
        .wb_mem_valid(wb_mem_valid), .wb_mem_ready(wb_mem_ready),
        .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
        .wb_alu_valid(wb_alu_valid), .wb_alu_ready(wb_alu_ready),
        .wb_alu_addr(wb_alu_addr), .wb_alu_data(wb_alu_data),
        .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
        .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
        .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Register file environment: combinational read, write on the rising edge.
    logic [DW-1:0] rf_mem [32];
    assign rf_rdata_0 = rf_mem[rf_raddr_0];
    assign rf_rdata_1 = rf_mem[rf_raddr_1];

    function automatic logic [DW-1:0] init_val(input int i);
        return {32'hC0DE_0000 + i, 32'h1000_0000 + i * 7};
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_write_en) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    // Reference model state: architectural registers, pending writes, RR pointer.
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int id; logic [DW-1:0] d0; logic [DW-1:0] d1; } rsp_t;

    logic [DW-1:0] shadow [32];
    wr_t  wq[$];
    rsp_t rspq[$];
    int   rr;
    int   total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every registered response must match the oldest expectation.
    always @(negedge clk) begin : mon
        rsp_t r;
        if (!reset) begin
            if (rd_rsp_valid) begin
                if (rspq.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    r = rspq.pop_front();
                    chk("rsp_id", 64'(rd_rsp_id), 64'(r.id));
                    chk("rsp_data0", rd_rsp_data0, r.d0);
                    chk("rsp_data1", rd_rsp_data1, r.d1);
                end
            end else if (rspq.size() != 0) begin
                r = rspq.pop_front();
                chk("rsp_missing", 64'd0, 64'd1);
            end
        end
    end

    // One cycle: drive at the falling edge, check against the model, update at the rising edge.
    task automatic step(input logic [N-1:0] rv, input logic [N-1:0][AW-1:0] a0,
                        input logic [N-1:0][AW-1:0] a1, input logic [N-1:0][1:0] use_m,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        int free, g;
        bit mrdy, ardy, macc, aacc, blk;
        logic [AW-1:0] oa;
        logic [N-1:0] exp_rdy;
        rsp_t r;
        wr_t  w;
        rd_req_valid = rv; rd_req_addr0 = a0; rd_req_addr1 = a1; rd_req_use = use_m;
        wb_mem_valid = mv; wb_mem_addr = ma; wb_mem_data = md;
        wb_alu_valid = av; wb_alu_addr = aa; wb_alu_data = ad;
        #1;
        free = DEPTH - wq.size();
        mrdy = free >= 1;
        ardy = (free >= 2) || (free >= 1 && !mv);
        macc = mv && mrdy;
        aacc = av && ardy;
        chk("wb_mem_ready", 64'(wb_mem_ready), 64'(mrdy));
        chk("wb_alu_ready", 64'(wb_alu_ready), 64'(ardy));
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            blk = 0;
            for (int op = 0; op < 2; op++) begin
                oa = (op == 1) ? a1[i] : a0[i];
                if (use_m[i][op]) begin
                    if ((macc && ma == oa) || (aacc && aa == oa)) blk = 1;
                    foreach (wq[e]) if (wq[e].addr == oa) blk = 1;
                end
            end
            if (g < 0 && rv[i] && !blk) g = i;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("rd_req_ready", 64'(rd_req_ready), 64'(exp_rdy));
        chk("rf_read_en", 64'(rf_read_en), (g >= 0) ? 64'(use_m[g]) : 64'd0);
        chk("rf_raddr_0", 64'(rf_raddr_0), (g >= 0 && use_m[g][0]) ? 64'(a0[g]) : 64'd0);
        chk("rf_raddr_1", 64'(rf_raddr_1), (g >= 0 && use_m[g][1]) ? 64'(a1[g]) : 64'd0);
        chk("rf_write_en", 64'(rf_write_en), 64'(wq.size() != 0));
        if (wq.size() != 0) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(wq[0].addr));
            chk("rf_wdata", rf_wdata, wq[0].data);
        end
        if (g >= 0) begin
            r.id = g;
            r.d0 = use_m[g][0] ? shadow[a0[g]] : '0;
            r.d1 = use_m[g][1] ? shadow[a1[g]] : '0;
            rspq.push_back(r);
        end
        @(posedge clk);
        if (wq.size() != 0) begin
            w = wq.pop_front();
            shadow[w.addr] = w.data;
        end
        if (macc) begin w.addr = ma; w.data = md; wq.push_back(w); end
        if (aacc) begin w.addr = aa; w.data = ad; wq.push_back(w); end
        if (g >= 0) rr = (g + 1) % N;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_req_ready"}, 64'(rd_req_ready), 64'd0);
        chk({tag, "_wb_mem_ready"}, 64'(wb_mem_ready), 64'd0);
        chk({tag, "_wb_alu_ready"}, 64'(wb_alu_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rd_rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rd_rsp_id), 64'd0);
        chk({tag, "_rsp_data0"}, rd_rsp_data0, 64'd0);
        chk({tag, "_rsp_data1"}, rd_rsp_data1, 64'd0);
        chk({tag, "_rf_read_en"}, 64'(rf_read_en), 64'd0);
        chk({tag, "_rf_raddr_0"}, 64'(rf_raddr_0), 64'd0);
        chk({tag, "_rf_raddr_1"}, 64'(rf_raddr_1), 64'd0);
        chk({tag, "_rf_write_en"}, 64'(rf_write_en), 64'd0);
        chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 64'd0);
    endtask

    task automatic rf_vs_model(input string tag);
        for (int i = 0; i < 32; i++) chk(tag, rf_mem[i], shadow[i]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        logic [DW-1:0] d0, d1;
        reset = 1'b1; preload = 1'b1;
        rd_req_valid = '0; rd_req_addr0 = '0; rd_req_addr1 = '0; rd_req_use = '0;
        wb_mem_valid = 0; wb_mem_addr = '0; wb_mem_data = '0;
        wb_alu_valid = 0; wb_alu_addr = '0; wb_alu_data = '0;
        rr = 0;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_req_valid = '1; rd_req_use = '1; wb_mem_valid = 1; wb_alu_valid = 1;
        #1 check_zero("reset");
        rd_req_valid = '0; rd_req_use = '0; wb_mem_valid = 0; wb_alu_valid = 0;
        preload = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);

        // r5 writeback: read of r5 blocked on accept and drain cycles, then granted.
        step(2'b01, {5'd0, 5'd5}, '0, {2'b00, 2'b01}, 0, '0, '0, 1, 5'd5, 64'hDEAD_BEEF_0123_4567);
        for (int i = 0; i < 3; i++) step(2'b01, {5'd0, 5'd5}, '0, {2'b00, 2'b01}, 0, '0, '0, 0, '0, '0);
        chk("r5_written", rf_mem[5], 64'hDEAD_BEEF_0123_4567);

        // Both requesters on clean registers: grants alternate.
        for (int i = 0; i < 6; i++) step(2'b11, {5'd3, 5'd1}, {5'd4, 5'd2}, {2'b11, 2'b11}, 0, '0, '0, 0, '0, '0);

        // Same-address collision: memory is ordered before ALU, so ALU wins.
        step('0, '0, '0, '0, 1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
        idle(3);
        chk("r7_alu_last", rf_mem[7], 64'h2);

        // Back-to-back dual writebacks push the FIFO to its steady-state limit.
        for (int i = 0; i < 5; i++)
            step('0, '0, '0, '0, 1, AW'(10 + 2 * i), 64'(100 + i), 1, AW'(11 + 2 * i), 64'(200 + i));
        idle(4);

        // Only operand 1 used.
        step(2'b10, '0, {5'd9, 5'd0}, {2'b10, 2'b00}, 0, '0, '0, 0, '0, '0);
        idle(1);

        // Reset with three queued writes and a live response.
        step(2'b01, {5'd0, 5'd1}, '0, {2'b00, 2'b01}, 1, 5'd20, 64'hAAAA, 1, 5'd21, 64'hBBBB);
        step(2'b01, {5'd0, 5'd2}, '0, {2'b00, 2'b01}, 1, 5'd22, 64'hCCCC, 1, 5'd23, 64'hDDDD);
        #3 reset = 1'b1;
        wq.delete(); rspq.delete(); rr = 0;
        #1 check_zero("midreset");
        rd_req_valid = '0; rd_req_use = '0; wb_mem_valid = 0; wb_alu_valid = 0;
        @(negedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        rf_vs_model("rf_after_reset");
        chk("r21_discarded", rf_mem[21], init_val(21));

        // Random traffic over a narrow address window to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0][AW-1:0] ra0, ra1;
            logic [N-1:0][1:0]    ru;
            for (int i = 0; i < N; i++) begin
                ra0[i] = AW'($urandom_range(0, 7));
                ra1[i] = AW'($urandom_range(0, 7));
                ru[i]  = 2'($urandom_range(0, 3));
            end
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            step(N'($urandom_range(0, 3)), ra0, ra1, ru,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), d0,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), d1);
        end
        idle(6);
        rf_vs_model("rf_final");
        chk("rsp_queue_drained", 64'(rspq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
